// File: rtl/magnitude_scheduler.sv
// Round-robin scheduler that shares one magnitude pipeline among NUM_CH I/Q channels.
// Results come back in issue order and are tagged with the originating channel.
module magnitude_scheduler #(
    parameter int NUM_CH        = 4,
    parameter int DATA_IN_BITS  = 16,
    parameter int DATA_OUT_BITS = DATA_IN_BITS + 1,
    parameter int PIPE_LATENCY  = 5,
    parameter int FIFO_DEPTH    = 8,
    parameter int CH_BITS       = $clog2(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              req_valid,
    input  logic [NUM_CH*DATA_IN_BITS-1:0] req_data_1,
    input  logic [NUM_CH*DATA_IN_BITS-1:0] req_data_2,
    output logic [NUM_CH-1:0]              req_ready,
    output logic [DATA_IN_BITS-1:0]        mag_data_in_1,
    output logic [DATA_IN_BITS-1:0]        mag_data_in_2,
    output logic                           mag_data_in_ready,
    input  logic [DATA_OUT_BITS-1:0]       mag_data_out,
    input  logic                           mag_data_out_ready,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [DATA_OUT_BITS-1:0]       res_data,
    output logic [CH_BITS-1:0]             res_ch,
    output logic                           tag_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(PIPE_LATENCY + 1);
    localparam int IW = CH_BITS + 1;

    typedef struct packed {
        logic [CH_BITS-1:0]       ch;
        logic [DATA_OUT_BITS-1:0] data;
    } res_t;

    logic [NUM_CH-1:0][DATA_IN_BITS-1:0] ch_i, ch_q;
    logic [CH_BITS-1:0] ptr, grant_idx;
    logic [IW-1:0]      idx;
    logic               grant_any, issue_ok, xfer, flushing;
    logic               mag_hit, tag_pop, tag_empty, res_pop;
    logic [CW-1:0]      outstanding, tag_cnt, res_cnt;
    logic [AW-1:0]      tag_wr, tag_rd, res_wr, res_rd;
    logic [FW-1:0]      flush_cnt;
    logic [CH_BITS-1:0] tag_mem [FIFO_DEPTH];
    res_t               res_mem [FIFO_DEPTH];
    res_t               head;

    assign ch_i = req_data_1;
    assign ch_q = req_data_2;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = {1'b0, ptr} + IW'(i);
            if (idx >= IW'(NUM_CH))
                idx = idx - IW'(NUM_CH);
            if (!grant_any && req_valid[idx[CH_BITS-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = idx[CH_BITS-1:0];
            end
        end
    end

    assign flushing  = (flush_cnt != '0);
    assign res_valid = (res_cnt != '0);
    assign res_pop   = res_valid && res_ready;
    // A pop in the same cycle frees a slot, so a full scheduler may still issue.
    assign issue_ok  = !rst && !flushing && ((outstanding < CW'(FIFO_DEPTH)) || res_pop);
    assign xfer      = grant_any && issue_ok;
    assign req_ready = xfer ? (NUM_CH'(1) << grant_idx) : '0;

    assign tag_empty = (tag_cnt == '0);
    assign mag_hit   = mag_data_out_ready && !flushing && !rst;
    assign tag_pop   = mag_hit && !tag_empty;

    assign head     = res_mem[res_rd];
    assign res_data = res_valid ? head.data : '0;
    assign res_ch   = res_valid ? head.ch : '0;

    always_ff @(posedge clk) begin
        if (xfer)
            tag_mem[tag_wr] <= grant_idx;
        if (tag_pop)
            res_mem[res_wr] <= {tag_mem[tag_rd], mag_data_out};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr               <= CH_BITS'(NUM_CH - 1);
            flush_cnt         <= FW'(PIPE_LATENCY);
            outstanding       <= '0;
            tag_cnt           <= '0;
            tag_wr            <= '0;
            tag_rd            <= '0;
            res_cnt           <= '0;
            res_wr            <= '0;
            res_rd            <= '0;
            mag_data_in_ready <= 1'b0;
            mag_data_in_1     <= '0;
            mag_data_in_2     <= '0;
            tag_error         <= 1'b0;
        end else begin
            // Results still draining from before reset are dropped while flushing.
            if (flushing)
                flush_cnt <= flush_cnt - FW'(1);
            mag_data_in_ready <= xfer;
            if (xfer) begin
                ptr           <= grant_idx;
                mag_data_in_1 <= ch_i[grant_idx];
                mag_data_in_2 <= ch_q[grant_idx];
                tag_wr        <= tag_wr + AW'(1);
            end
            if (tag_pop) begin
                tag_rd <= tag_rd + AW'(1);
                res_wr <= res_wr + AW'(1);
            end
            if (res_pop)
                res_rd <= res_rd + AW'(1);
            tag_cnt     <= tag_cnt + CW'(xfer) - CW'(tag_pop);
            res_cnt     <= res_cnt + CW'(tag_pop) - CW'(res_pop);
            outstanding <= outstanding + CW'(xfer) - CW'(res_pop);
            if (mag_hit && tag_empty)
                tag_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_magnitude_scheduler.sv
// Scoreboard bench for magnitude_scheduler with a behavioural magnitude pipeline
// (integer sqrt of I^2+Q^2, fixed latency) attached to the issue/result ports.
module tb_magnitude_scheduler;
    localparam int NC = 4;
    localparam int DI = 16;
    localparam int DO = DI + 1;
    localparam int PL = 5;
    localparam int FD = 8;
    localparam int CB = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     req_valid;
    logic [NC*DI-1:0]  req_data_1, req_data_2;
    logic [NC-1:0]     req_ready;
    logic [DI-1:0]     mag_data_in_1, mag_data_in_2;
    logic              mag_data_in_ready;
    logic [DO-1:0]     mag_data_out;
    logic              mag_data_out_ready;
    logic              res_valid, res_ready;
    logic [DO-1:0]     res_data;
    logic [CB-1:0]     res_ch;
    logic              tag_error;
    logic              inj = 1'b0;

    magnitude_scheduler #(
        .NUM_CH(NC), .DATA_IN_BITS(DI), .DATA_OUT_BITS(DO),
        .PIPE_LATENCY(PL), .FIFO_DEPTH(FD), .CH_BITS(CB)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data_1(req_data_1), .req_data_2(req_data_2),
        .req_ready(req_ready),
        .mag_data_in_1(mag_data_in_1), .mag_data_in_2(mag_data_in_2),
        .mag_data_in_ready(mag_data_in_ready),
        .mag_data_out(mag_data_out), .mag_data_out_ready(mag_data_out_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_ch(res_ch), .tag_error(tag_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit lat_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] isqrt(input logic [63:0] v);
        logic [63:0] r, t;
        r = '0;
        for (int b = 20; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= v) r = t;
        end
        return r;
    endfunction

    function automatic logic [DO-1:0] mag(input logic [DI-1:0] i, input logic [DI-1:0] q);
        logic [63:0] iv, qv;
        iv = 64'(i);
        qv = 64'(q);
        return DO'(isqrt(iv * iv + qv * qv));
    endfunction

    // Magnitude pipeline model; deliberately not reset so in-flight results survive a reset.
    logic [PL-1:0] pv = '0;
    logic [DO-1:0] pd [PL];
    always @(posedge clk) begin
        pv    <= {pv[PL-2:0], mag_data_in_ready};
        pd[0] <= mag(mag_data_in_1, mag_data_in_2);
        for (int i = 1; i < PL; i++) pd[i] <= pd[i-1];
    end
    assign mag_data_out_ready = pv[PL-1] | inj;
    assign mag_data_out       = pd[PL-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [CB-1:0] ch;
        logic [DO-1:0] mag;
        int            cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    bit   held = 1'b0;
    logic [CB+DO-1:0] held_val;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            held = 1'b0;
        end else begin
            if (req_ready != '0) begin
                chk("grant_onehot", $onehot(req_ready), 1);
                chk("grant_without_valid", req_ready & ~req_valid, 0);
            end
            for (int c = 0; c < NC; c++)
                if (req_ready[c] && req_valid[c]) begin
                    mon_e.ch  = CB'(c);
                    mon_e.mag = mag(req_data_1[c*DI +: DI], req_data_2[c*DI +: DI]);
                    mon_e.cyc = cyc;
                    sb.push_back(mon_e);
                end
            if (held) chk("res_stable", {res_valid, res_ch, res_data}, {1'b1, held_val});
            held     = res_valid && !res_ready;
            held_val = {res_ch, res_data};
            if (res_valid && res_ready) begin
                if (sb.size() == 0) chk("res_unexpected", res_valid, 0);
                else begin
                    mon_e = sb.pop_front();
                    chk("res_ch", res_ch, mon_e.ch);
                    chk("res_data", res_data, mon_e.mag);
                    if (lat_mode) chk("latency", cyc - mon_e.cyc, PL + 2);
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && !res_valid) break;
            nxt();
        end
        @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        chk("drain_res_valid", res_valid, 0);
        nxt();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int n;

    initial begin
        rst        = 1'b1;
        req_valid  = '1;
        res_ready  = 1'b1;
        req_data_1 = {16'd8, 16'd5, 16'd6, 16'd3};
        req_data_2 = {16'd15, 16'd12, 16'd8, 16'd4};
        repeat (3) nxt();
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mag_in_ready", mag_data_in_ready, 0);
        chk("rst_mag_in_1", mag_data_in_1, 0);
        chk("rst_mag_in_2", mag_data_in_2, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_ch", res_ch, 0);
        chk("rst_tag_error", tag_error, 0);
        nxt();
        rst = 1'b0;
        for (int k = 0; k < PL; k++) begin
            @(negedge clk);
            chk("flush_req_ready", req_ready, 0);
            nxt();
        end

        // round robin over all four channels, fixed latency
        lat_mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant", req_ready, 4'b0001 << (k % 4));
            if (k == 7) begin
                chk("ch0_res_valid", res_valid, 1);
                chk("ch0_res_data", res_data, 5);
                chk("ch0_res_ch", res_ch, 0);
            end
            nxt();
        end
        drain();
        lat_mode = 1'b0;

        // back-pressure: the result path fills after FIFO_DEPTH issues
        req_valid = 4'b0010;
        res_ready = 1'b0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (req_ready[1]) n++;
            nxt();
        end
        chk("issue_count_full", n, FD);
        @(negedge clk);
        chk("full_block", req_ready, 0);
        repeat (8) nxt();
        res_ready = 1'b1;
        @(negedge clk);
        chk("pulse_res_valid", res_valid, 1);
        chk("grant_on_pop", req_ready, 4'b0010);
        nxt();
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("full_after_pop", req_ready, 0);
            nxt();
        end
        drain();

        // single requester, then wrap to a lower channel
        req_valid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("solo_ch2", req_ready, 4'b0100);
            nxt();
        end
        req_valid = 4'b0101;
        @(negedge clk);
        chk("wrap_ch0", req_ready, 4'b0001);
        nxt();
        @(negedge clk);
        chk("back_ch2", req_ready, 4'b0100);
        nxt();
        drain();

        // random traffic with random back-pressure
        for (int k = 0; k < 300; k++) begin
            req_valid  = NC'($urandom);
            res_ready  = ($urandom_range(0, 3) != 0);
            req_data_1 = {$urandom, $urandom};
            req_data_2 = {$urandom, $urandom};
            nxt();
        end
        drain();

        // reset with results in flight
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("pre_rst_grant", req_ready, 4'b0001);
            nxt();
        end
        req_valid = '0;
        repeat (2) nxt();
        rst = 1'b1;
        nxt();
        rst       = 1'b0;
        req_valid = '1;
        for (int k = 0; k < PL; k++) begin
            @(negedge clk);
            chk("post_rst_flush", req_ready, 0);
            chk("post_rst_res_valid", res_valid, 0);
            chk("post_rst_tag_error", tag_error, 0);
            nxt();
        end
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", {res_valid, tag_error}, 0);
            nxt();
        end

        // spurious pipeline result with nothing outstanding
        @(negedge clk);
        chk("tag_error_clear", tag_error, 0);
        nxt();
        inj = 1'b1;
        nxt();
        inj = 1'b0;
        @(negedge clk);
        chk("tag_error_set", tag_error, 1);
        chk("spurious_res_valid", res_valid, 0);
        repeat (4) nxt();
        @(negedge clk);
        chk("tag_error_sticky", tag_error, 1);
        chk("spurious_res_valid_late", res_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
